// File: rtl/if_resp_tracker_pkg.sv
// Shared fetch definitions: default address/instruction widths and the IB packet layout {err, vaddr, inst}.
package if_resp_tracker_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int INST_W_DEF = 32;

  typedef struct packed {
    logic                  err;
    logic [ADDR_W_DEF-1:0] vaddr;
    logic [INST_W_DEF-1:0] inst;
  } ib_pkt_t;

  localparam int IB_PKT_W = $bits(ib_pkt_t);

  // Packet width for non-default address/instruction widths.
  function automatic int ib_pkt_w(input int addr_w, input int inst_w);
    return 1 + addr_w + inst_w;
  endfunction

endpackage

// File: rtl/if_req_fifo.sv
// In-order queue of outstanding fetch addresses, each with a kill bit set by kill_all.
// Zero-latency head view; the caller must not push when full or pop when empty.
module if_req_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  input  logic              kill_all,
  output logic [ADDR_W-1:0] head_addr,
  output logic              head_kill,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DEPTH-1:0]  kill_q;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  off [DEPTH];
  logic [DEPTH-1:0]  live;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign head_addr = addr_q[rd_ptr];
  assign head_kill = kill_q[rd_ptr];
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);

  // A slot is resident when its distance from the head is below the occupancy.
  always_comb begin
    live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off[i]  = PTR_W'(i) - rd_ptr;
      live[i] = (CNT_W'(off[i]) < count_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
      kill_q  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_all && live[i]) kill_q[i] <= 1'b1;
      end
      if (push) begin
        addr_q[wr_ptr] <= push_addr;
        kill_q[wr_ptr] <= 1'b0;
        wr_ptr         <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/if_resp_tracker.sv
// Pairs returning instructions with their fetch addresses and discards responses to pre-redirect requests.
// One-cycle response-to-IB latency; responses are held off while the output packet is stalled by ib_ready.
module if_resp_tracker
  import if_resp_tracker_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [ADDR_W-1:0] vaddr,
  input  logic              vaddr_valid,
  output logic              vaddr_ready,
  input  logic [INST_W-1:0] inst_i,
  input  logic              inst_err,
  input  logic              inst_valid,
  output logic              inst_ready,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] vaddr_o,
  output logic              err_o,
  output logic              ib_valid,
  input  logic              ib_ready,
  output logic              idle
);

  localparam int PKT_W = ib_pkt_w(ADDR_W, INST_W);

  logic              push;
  logic              pop;
  logic              load;
  logic [ADDR_W-1:0] head_addr;
  logic              head_kill;
  logic              full;
  logic              empty;
  logic [PKT_W-1:0]  pkt_q;

  if_req_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (vaddr),
    .pop       (pop),
    .kill_all  (flush),
    .head_addr (head_addr),
    .head_kill (head_kill),
    .full      (full),
    .empty     (empty)
  );

  // Killed heads and flush-cycle responses never reach the output, so they bypass the stall.
  assign vaddr_ready = !full && !flush;
  assign inst_ready  = !empty && (head_kill || flush || !ib_valid || ib_ready);
  assign push        = vaddr_valid && vaddr_ready;
  assign pop         = inst_valid && inst_ready;
  assign load        = pop && !head_kill && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ib_valid <= 1'b0;
      pkt_q    <= '0;
    end else if (flush) begin
      ib_valid <= 1'b0;
    end else if (load) begin
      ib_valid <= 1'b1;
      pkt_q    <= {inst_err, head_addr, inst_i};
    end else if (ib_ready) begin
      ib_valid <= 1'b0;
    end
  end

  assign {err_o, vaddr_o, inst_o} = pkt_q;
  assign idle = empty && !ib_valid;

endmodule

// File: tb/tb_if_resp_tracker.sv
// Directed bench for if_resp_tracker: pairing, backpressure, flush drain, flush/pop collision, wrap, async reset.
module tb_if_resp_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] vaddr;
  logic        vaddr_valid;
  logic        vaddr_ready;
  logic [31:0] inst_i;
  logic        inst_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [31:0] vaddr_o;
  logic        err_o;
  logic        ib_valid;
  logic        ib_ready;
  logic        idle;

  int checks = 0;
  int errors = 0;

  if_resp_tracker #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .vaddr       (vaddr),
    .vaddr_valid (vaddr_valid),
    .vaddr_ready (vaddr_ready),
    .inst_i      (inst_i),
    .inst_err    (inst_err),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_o      (inst_o),
    .vaddr_o     (vaddr_o),
    .err_o       (err_o),
    .ib_valid    (ib_valid),
    .ib_ready    (ib_ready),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet;
    flush = 1'b0; vaddr_valid = 1'b0; inst_valid = 1'b0; inst_err = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] a);
    vaddr = a; vaddr_valid = 1'b1;
    #1;
    checks++;
    if (vaddr_ready !== 1'b1) begin
      errors++; $display("FAIL push_ready addr=%h: got %b want 1", a, vaddr_ready);
    end
    step;
    vaddr_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; ib_ready = 1'b1; vaddr = '0; inst_i = '0;
    quiet;
    #12;
    checks++;
    if ({ib_valid, err_o} !== 2'b00) begin
      errors++; $display("FAIL reset_valid_err: got %b want 00", {ib_valid, err_o});
    end
    checks++;
    if ({inst_o, vaddr_o} !== 64'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {inst_o, vaddr_o});
    end
    checks++;
    if ({vaddr_ready, inst_ready, idle} !== 3'b101) begin
      errors++; $display("FAIL reset_ready_idle: got %b want 101", {vaddr_ready, inst_ready, idle});
    end
    @(negedge clk);
    reset = 1'b1;
    step;
  endtask

  task automatic test_basic;
    ib_ready = 1'b1;
    push_one(32'h1c000000);
    push_one(32'h1c000004);
    inst_i = 32'h02800421; inst_valid = 1'b1;
    #1;
    checks++;
    if (inst_ready !== 1'b1) begin
      errors++; $display("FAIL basic_inst_ready: got %b want 1", inst_ready);
    end
    step;
    checks++;
    if ({ib_valid, vaddr_o, inst_o, err_o} !== {1'b1, 32'h1c000000, 32'h02800421, 1'b0}) begin
      errors++; $display("FAIL basic_pkt0: got v=%b a=%h i=%h e=%b want 1 1c000000 02800421 0",
                         ib_valid, vaddr_o, inst_o, err_o);
    end
    inst_i = 32'h02800842;
    step;
    checks++;
    if ({ib_valid, vaddr_o, inst_o} !== {1'b1, 32'h1c000004, 32'h02800842}) begin
      errors++; $display("FAIL basic_pkt1: got v=%b a=%h i=%h want 1 1c000004 02800842",
                         ib_valid, vaddr_o, inst_o);
    end
    inst_valid = 1'b0;
    step;
    checks++;
    if ({ib_valid, idle} !== 2'b01) begin
      errors++; $display("FAIL basic_drain: got v/idle=%b want 01", {ib_valid, idle});
    end
  endtask

  task automatic test_full;
    ib_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(32'h1c000200 + 32'(4 * i));
    vaddr = 32'h1c0002f0; vaddr_valid = 1'b1;
    inst_i = 32'h11110000; inst_valid = 1'b1;
    #1;
    checks++;
    if ({vaddr_ready, inst_ready} !== 2'b01) begin
      errors++; $display("FAIL full_ready: got vr/ir=%b want 01", {vaddr_ready, inst_ready});
    end
    step;
    vaddr_valid = 1'b0;
    inst_i = 32'h11110001;
    #1;
    checks++;
    if (inst_ready !== 1'b0) begin
      errors++; $display("FAIL stall_inst_ready: got %b want 0", inst_ready);
    end
    step;
    checks++;
    if ({ib_valid, vaddr_o, inst_o} !== {1'b1, 32'h1c000200, 32'h11110000}) begin
      errors++; $display("FAIL stall_hold: got v=%b a=%h i=%h want 1 1c000200 11110000",
                         ib_valid, vaddr_o, inst_o);
    end
    ib_ready = 1'b1;
    #1;
    checks++;
    if (inst_ready !== 1'b1) begin
      errors++; $display("FAIL unstall_inst_ready: got %b want 1", inst_ready);
    end
    step;
    checks++;
    if ({ib_valid, vaddr_o, inst_o} !== {1'b1, 32'h1c000204, 32'h11110001}) begin
      errors++; $display("FAIL unstall_pkt: got v=%b a=%h i=%h want 1 1c000204 11110001",
                         ib_valid, vaddr_o, inst_o);
    end
    inst_i = 32'h11110002; step;
    inst_i = 32'h11110003; step;
    checks++;
    if (vaddr_o !== 32'h1c00020c) begin
      errors++; $display("FAIL full_last_pkt: got %h want 1c00020c", vaddr_o);
    end
    inst_valid = 1'b0;
    step;
    checks++;
    if (idle !== 1'b1) begin
      errors++; $display("FAIL full_idle: got %b want 1", idle);
    end
  endtask

  task automatic test_flush_drain;
    ib_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_one(32'h1c000300 + 32'(4 * i));
    flush = 1'b1; vaddr = 32'h1c000100; vaddr_valid = 1'b1;
    #1;
    checks++;
    if (vaddr_ready !== 1'b0) begin
      errors++; $display("FAIL flush_push_refused: got %b want 0", vaddr_ready);
    end
    step;
    flush = 1'b0; vaddr_valid = 1'b0;
    push_one(32'h1c000100);
    for (int i = 0; i < 3; i++) begin
      inst_i = 32'hdead0000 + 32'(i); inst_valid = 1'b1;
      #1;
      checks++;
      if (inst_ready !== 1'b1) begin
        errors++; $display("FAIL drain_ready%0d: got %b want 1", i, inst_ready);
      end
      step;
      checks++;
      if (ib_valid !== 1'b0) begin
        errors++; $display("FAIL drain_discard%0d: got ib_valid %b want 0", i, ib_valid);
      end
    end
    inst_i = 32'h02800c63;
    step;
    checks++;
    if ({ib_valid, vaddr_o, inst_o} !== {1'b1, 32'h1c000100, 32'h02800c63}) begin
      errors++; $display("FAIL drain_pair: got v=%b a=%h i=%h want 1 1c000100 02800c63",
                         ib_valid, vaddr_o, inst_o);
    end
    inst_valid = 1'b0;
    step;
  endtask

  task automatic test_flush_pop;
    ib_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_one(32'h1c000400 + 32'(4 * i));
    inst_i = 32'h22220000; inst_valid = 1'b1;
    step;
    ib_ready = 1'b0; flush = 1'b1; inst_i = 32'h22220001;
    #1;
    checks++;
    if (inst_ready !== 1'b1) begin
      errors++; $display("FAIL collide_ready: got %b want 1", inst_ready);
    end
    step;
    flush = 1'b0; inst_i = 32'h22220002;
    checks++;
    if ({ib_valid, idle} !== 2'b00) begin
      errors++; $display("FAIL collide_drop: got v/idle=%b want 00", {ib_valid, idle});
    end
    step;
    inst_valid = 1'b0;
    checks++;
    if ({ib_valid, idle} !== 2'b01) begin
      errors++; $display("FAIL collide_killed: got v/idle=%b want 01", {ib_valid, idle});
    end
    ib_ready = 1'b1;
  endtask

  task automatic test_back_to_back;
    ib_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      vaddr_valid = (i < 10);
      vaddr       = 32'h1c001000 + 32'(4 * i);
      inst_valid  = (i > 0);
      inst_i      = 32'h0a000000 + 32'(i) - 32'd1;
      inst_err    = (i == 6);
      #1;
      if (i > 0) begin
        checks++;
        if (inst_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, inst_ready);
        end
      end
      step;
      if (i > 0) begin
        checks++;
        if ({ib_valid, vaddr_o, inst_o, err_o} !==
            {1'b1, 32'h1c001000 + 32'(4 * (i - 1)), 32'h0a000000 + 32'(i - 1), (i == 6)}) begin
          errors++; $display("FAIL b2b_pkt%0d: got v=%b a=%h i=%h e=%b", i - 1, ib_valid, vaddr_o, inst_o, err_o);
        end
      end
    end
    quiet;
    step;
    checks++;
    if ({idle, ib_valid} !== 2'b10) begin
      errors++; $display("FAIL b2b_idle: got idle/v=%b want 10", {idle, ib_valid});
    end
  endtask

  task automatic test_async_reset;
    ib_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_one(32'h1c000500 + 32'(4 * i));
    inst_i = 32'h33330000; inst_err = 1'b1; inst_valid = 1'b1;
    step;
    quiet;
    checks++;
    if ({ib_valid, err_o} !== 2'b11) begin
      errors++; $display("FAIL prereset_pkt: got v/e=%b want 11", {ib_valid, err_o});
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({ib_valid, err_o, inst_o, vaddr_o} !== 66'h0) begin
      errors++; $display("FAIL async_outputs: got v=%b e=%b i=%h a=%h want all 0", ib_valid, err_o, inst_o, vaddr_o);
    end
    checks++;
    if ({vaddr_ready, inst_ready, idle} !== 3'b101) begin
      errors++; $display("FAIL async_ready_idle: got %b want 101", {vaddr_ready, inst_ready, idle});
    end
    @(negedge clk);
    reset = 1'b1;
    push_one(32'h1c000600);
    inst_i = 32'h44440000; inst_valid = 1'b1;
    step;
    inst_valid = 1'b0;
    checks++;
    if ({ib_valid, vaddr_o} !== {1'b1, 32'h1c000600}) begin
      errors++; $display("FAIL post_reset_pair: got v=%b a=%h want 1 1c000600", ib_valid, vaddr_o);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_full;
    test_flush_drain;
    test_flush_pop;
    test_back_to_back;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_resp_tracker.md
# if_resp_tracker

Fetch-stage request/response tracker between the PC generator and the instruction buffer. It records every accepted fetch address in an in-order outstanding queue of up to DEPTH entries. Each returning instruction is paired with its address, and responses belonging to requests issued before a redirect are drained and discarded. Paired {vaddr, inst, err} packets are registered toward the instruction buffer with a valid/ready handshake.

## Interface
- ADDR_W, 32, fetch address width
- INST_W, 32, instruction word width
- DEPTH, 4, maximum outstanding fetch requests; power of two, ≥2
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  redirect this cycle (branch/exception/ertn, pre-ORed upstream)
- vaddr  in  ADDR_W  fetch address issued to memory
- vaddr_valid  in  1  request present
- vaddr_ready  out  1  tracker can record a new request
- inst_i  in  INST_W  returned instruction
- inst_err  in  1  bus/access error on this response
- inst_valid  in  1  response present
- inst_ready  out  1  tracker accepts the response
- inst_o  out  INST_W  instruction to IB
- vaddr_o  out  ADDR_W  paired address to IB
- err_o  out  1  fetch error flag to IB
- ib_valid  out  1  output packet valid
- ib_ready  in  1  IB accepts packet
- idle  out  1  no outstanding requests, output empty

## Operation
- Queue entry = {vaddr, kill}; FIFO with wr_ptr/rd_ptr modulo DEPTH, count width $clog2(DEPTH+1).
- Push: vaddr_valid & vaddr_ready. vaddr_ready = (count < DEPTH) & !flush; no same-cycle pop bypass.
- Pop: inst_valid & inst_ready. inst_ready = (count != 0) & (head.kill | flush | !ib_valid | ib_ready).
- Popped live entry with no flush → output register loads {inst_i, head.vaddr, inst_err}, ib_valid=1.
- Popped entry with kill=1, or popped during a flush cycle → discarded; output is not loaded.
- Flush: all entries resident at the edge (excluding the one popped that cycle) get kill=1; ib_valid cleared. Killed entries keep occupying slots until their responses drain.
- Output register holds its contents while ib_valid & !ib_ready. It is replaced when ib_ready is high in the same cycle as a new live pop.
- Upstream never returns a response with count==0; such a response stays unaccepted (inst_ready=0).
- idle = (count==0) & !ib_valid.

## Timing
- Reset values: ib_valid=0, inst_o=0, vaddr_o=0, err_o=0, count=0, pointers=0, all kill=0. Hence vaddr_ready=1, inst_ready=0, idle=1 out of reset.
- Asserting reset mid-operation drops all queue contents immediately.
- Response latency: accepted at edge T → ib_valid high in cycle T+1.
- Full throughput: one push and one pop per cycle at steady state with ib_ready=1.
- vaddr_ready depends only on registers and flush. inst_ready depends on registers, flush and ib_ready. There is no path from vaddr_valid or inst_valid into any ready.
- Simultaneous push+pop: count unchanged, both pointers advance.
- Full: count==DEPTH → vaddr_ready=0, including the cycle a pop occurs.
- Pointer wrap: rd_ptr/wr_ptr roll DEPTH-1→0.
- Flush + push same cycle: push refused.
- Flush + pop same cycle: response dropped, entry freed, remaining entries killed.

## Structure
- Shared fetch package/header: ADDR_W and INST_W defaults, and the IB packet layout {err, vaddr, inst} with its total width constant.
- One sub-module, if_req_fifo: DEPTH×(ADDR_W+1) storage, pointers, count, full/empty, and a kill_all input that sets every valid entry's kill bit.
- The top level holds handshake logic and the output register.

## Test plan
- Basic pairing: push 0x1c000000, 0x1c000004; responses 0x02800421, 0x02800842 with ib_ready=1 → IB sees {0x1c000000,0x02800421} then {0x1c000004,0x02800842}, one cycle after each accept.
- Full/backpressure: DEPTH=4, four pushes with no responses → vaddr_ready=0. ib_ready=0 with one response accepted → inst_ready=0 for the next response until ib_ready=1.
- Flush drain: 3 outstanding, flush, push 0x1c000100 → 3 responses accepted with ib_valid staying 0. The 4th response pairs with 0x1c000100.
- Flush + pop collision: flush in the same cycle as a response accept → response dropped, count decrements, remaining entries killed, ib_valid=0 next cycle.
- Error and wrap: 10 back-to-back push/pop pairs, one with inst_err=1 → pointers wrap, err_o=1 only on that packet, idle=1 at end.
- Async reset mid-stream: assert reset with 2 outstanding and ib_valid=1 → all outputs return to reset values without a clock edge.
